// File: rtl/stopwatch_core.sv
// stopwatch_core: centisecond stopwatch, 00.00 to 99.99 s in BCD, for fourdigitdriver.
// Raw start/stop and clear buttons are synchronized and edge-detected here.
// Optional lap/split display is enabled by defining STOPWATCH_LAP_EN, which
// adds the btn_lap port.
`timescale 1ns/1ps

module stopwatch_core #(
    parameter int unsigned TICK_DIV = 1_000_000,
    parameter int unsigned CNT_W    = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_ss,
    input  logic       btn_clr,
`ifdef STOPWATCH_LAP_EN
    input  logic       btn_lap,
`endif
    output logic [3:0] A,
    output logic [3:0] B,
    output logic [3:0] C,
    output logic [3:0] D,
    output logic [0:3] dots,
    output logic       running
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSE,
        MAXED
    } state_t;

    state_t state;

    logic [CNT_W-1:0] presc;
    logic             tick;

    logic [3:0] cnt_a;
    logic [3:0] cnt_b;
    logic [3:0] cnt_c;
    logic [3:0] cnt_d;

    logic [3:0] nxt_a;
    logic [3:0] nxt_b;
    logic [3:0] nxt_c;
    logic [3:0] nxt_d;
    logic       at_max;

    // [0] and [1] form the synchronizer, [2] is the edge-detect history
    logic [2:0] ss_sync;
    logic [2:0] clr_sync;
    logic       ss_pulse;
    logic       clr_pulse;

`ifdef STOPWATCH_LAP_EN
    logic [2:0] lap_sync;
    logic       lap_pulse;
    logic       lap_hold;
    logic [3:0] snap_a;
    logic [3:0] snap_b;
    logic [3:0] snap_c;
    logic [3:0] snap_d;
`endif

    // Two-flop synchronizers plus one history flop per button
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ss_sync  <= '0;
            clr_sync <= '0;
`ifdef STOPWATCH_LAP_EN
            lap_sync <= '0;
`endif
        end else begin
            ss_sync  <= {ss_sync[1:0], btn_ss};
            clr_sync <= {clr_sync[1:0], btn_clr};
`ifdef STOPWATCH_LAP_EN
            lap_sync <= {lap_sync[1:0], btn_lap};
`endif
        end
    end

    assign ss_pulse  = ss_sync[1] & ~ss_sync[2];
    assign clr_pulse = clr_sync[1] & ~clr_sync[2];
`ifdef STOPWATCH_LAP_EN
    assign lap_pulse = lap_sync[1] & ~lap_sync[2];
`endif

    // BCD increment of the live count, hundredths as least significant digit
    always_comb begin
        nxt_a = cnt_a;
        nxt_b = cnt_b;
        nxt_c = cnt_c;
        nxt_d = cnt_d;
        if (cnt_d == 4'd9) begin
            nxt_d = '0;
            if (cnt_c == 4'd9) begin
                nxt_c = '0;
                if (cnt_b == 4'd9) begin
                    nxt_b = '0;
                    nxt_a = (cnt_a == 4'd9) ? 4'd0 : cnt_a + 4'd1;
                end else begin
                    nxt_b = cnt_b + 4'd1;
                end
            end else begin
                nxt_c = cnt_c + 4'd1;
            end
        end else begin
            nxt_d = cnt_d + 4'd1;
        end
    end

    assign at_max = (cnt_a == 4'd9) && (cnt_b == 4'd9) &&
                    (cnt_c == 4'd9) && (cnt_d == 4'd9);

    // Control FSM with prescaler, registered tick, BCD count and lap snapshot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            presc <= '0;
            tick  <= 1'b0;
            cnt_a <= '0;
            cnt_b <= '0;
            cnt_c <= '0;
            cnt_d <= '0;
`ifdef STOPWATCH_LAP_EN
            lap_hold <= 1'b0;
            snap_a   <= '0;
            snap_b   <= '0;
            snap_c   <= '0;
            snap_d   <= '0;
`endif
        end else if (clr_pulse) begin
            // clear beats any simultaneous start/stop, tick or lap request
            state <= IDLE;
            presc <= '0;
            tick  <= 1'b0;
            cnt_a <= '0;
            cnt_b <= '0;
            cnt_c <= '0;
            cnt_d <= '0;
`ifdef STOPWATCH_LAP_EN
            lap_hold <= 1'b0;
`endif
        end else begin
            tick <= 1'b0;
            if (state == RUN) begin
                if (presc == CNT_W'(TICK_DIV - 1)) begin
                    presc <= '0;
                    tick  <= 1'b1;
                end else begin
                    presc <= presc + CNT_W'(1);
                end
            end

`ifdef STOPWATCH_LAP_EN
            if (lap_pulse && ((state == RUN) || (state == PAUSE))) begin
                lap_hold <= ~lap_hold;
                snap_a   <= cnt_a;
                snap_b   <= cnt_b;
                snap_c   <= cnt_c;
                snap_d   <= cnt_d;
            end
`endif

            if (tick && at_max) begin
                // saturate: the pending tick is consumed, start/stop is ignored
                state <= MAXED;
`ifdef STOPWATCH_LAP_EN
                lap_hold <= 1'b0;
`endif
            end else begin
                // a tick already issued is applied even if start/stop lands with it
                if (tick) begin
                    cnt_a <= nxt_a;
                    cnt_b <= nxt_b;
                    cnt_c <= nxt_c;
                    cnt_d <= nxt_d;
                end
                case (state)
                    IDLE:    if (ss_pulse) state <= RUN;
                    RUN:     if (ss_pulse) state <= PAUSE;
                    PAUSE:   if (ss_pulse) state <= RUN;
                    MAXED:   state <= MAXED;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign running = (state == RUN);

`ifdef STOPWATCH_LAP_EN
    assign A    = lap_hold ? snap_a : cnt_a;
    assign B    = lap_hold ? snap_b : cnt_b;
    assign C    = lap_hold ? snap_c : cnt_c;
    assign D    = lap_hold ? snap_d : cnt_d;
    assign dots = lap_hold ? 4'b0101 : 4'b0100;
`else
    assign A    = cnt_a;
    assign B    = cnt_b;
    assign C    = cnt_c;
    assign D    = cnt_d;
    assign dots = 4'b0100;
`endif

endmodule

// File: tb/tb_stopwatch_core.sv
// tb_stopwatch_core: directed test of stopwatch_core with TICK_DIV=4.
// Lap checks are included when STOPWATCH_LAP_EN is defined.
`timescale 1ns/1ps

module tb_stopwatch_core;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       btn_ss;
    logic       btn_clr;
`ifdef STOPWATCH_LAP_EN
    logic       btn_lap;
`endif
    logic [3:0] A;
    logic [3:0] B;
    logic [3:0] C;
    logic [3:0] D;
    logic [0:3] dots;
    logic       running;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    stopwatch_core #(
        .TICK_DIV (4),
        .CNT_W    (2)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_ss  (btn_ss),
        .btn_clr (btn_clr),
`ifdef STOPWATCH_LAP_EN
        .btn_lap (btn_lap),
`endif
        .A       (A),
        .B       (B),
        .C       (C),
        .D       (D),
        .dots    (dots),
        .running (running)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // advance n rising edges, then settle 1 ns past the last one
    task automatic step(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // raise pins just after an edge; the action lands on the 3rd edge
    task automatic press(input logic ss, input logic clr);
        btn_ss  = ss;
        btn_clr = clr;
        step(3);
        btn_ss  = 1'b0;
        btn_clr = 1'b0;
    endtask

`ifdef STOPWATCH_LAP_EN
    task automatic press_lap();
        btn_lap = 1'b1;
        step(3);
        btn_lap = 1'b0;
    endtask
`endif

    task automatic wait_for(input string tag, input logic [15:0] target, input int unsigned budget);
        int unsigned i = 0;
        while (({A, B, C, D} != target) && (i < budget)) begin
            step(1);
            i++;
        end
        check(tag, {A, B, C, D}, target);
    endtask

    initial begin
        rst_n   = 1'b0;
        btn_ss  = 1'b0;
        btn_clr = 1'b0;
`ifdef STOPWATCH_LAP_EN
        btn_lap = 1'b0;
`endif
        #1;
        check("rst_digits", {A, B, C, D}, 16'h0000);
        check("rst_dots", 16'(dots), 16'b0100);
        check("rst_running", 16'(running), 16'd0);
        step(2);
        @(negedge clk) rst_n = 1'b1;
        step(1);
        check("idle_digits", {A, B, C, D}, 16'h0000);

        // start, first tick timing, carries, 40 ticks
        press(1'b1, 1'b0);
        check("start_running", 16'(running), 16'd1);
        check("start_digits", {A, B, C, D}, 16'h0000);
        step(4);
        check("pre_first_tick", {A, B, C, D}, 16'h0000);
        step(1);
        check("first_tick", {A, B, C, D}, 16'h0001);
        step(32);
        check("tick9", {A, B, C, D}, 16'h0009);
        step(4);
        check("carry_0010", {A, B, C, D}, 16'h0010);
        step(119);
        check("tick39", {A, B, C, D}, 16'h0039);
        step(1);
        check("tick40", {A, B, C, D}, 16'h0040);

        // pause lands together with a tick: increment applied, then PAUSE
        step(1);
        press(1'b1, 1'b0);
        check("pause_digits", {A, B, C, D}, 16'h0041);
        check("pause_running", 16'(running), 16'd0);
        step(20);
        check("pause_hold", {A, B, C, D}, 16'h0041);
        press(1'b1, 1'b0);
        check("resume_running", 16'(running), 16'd1);
        step(3);
        check("resume_pre", {A, B, C, D}, 16'h0041);
        step(1);
        check("resume_presc_held", {A, B, C, D}, 16'h0042);

        // asynchronous reset mid-count
        wait_for("reach_0347", 16'h0347, 2000);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_digits", {A, B, C, D}, 16'h0000);
        check("async_rst_running", 16'(running), 16'd0);
        check("async_rst_dots", 16'(dots), 16'b0100);
        step(3);
        @(negedge clk) rst_n = 1'b1;
        step(4);
        check("post_rst_idle_digits", {A, B, C, D}, 16'h0000);
        check("post_rst_idle_running", 16'(running), 16'd0);

        // carry chain into tens
        press(1'b1, 1'b0);
        wait_for("reach_0999", 16'h0999, 5000);
        step(4);
        check("carry_1000", {A, B, C, D}, 16'h1000);

        // simultaneous start/stop and clear: clear wins
        wait_for("reach_1234", 16'h1234, 1500);
        press(1'b1, 1'b1);
        check("ss_clr_digits", {A, B, C, D}, 16'h0000);
        check("ss_clr_running", 16'(running), 16'd0);
        step(20);
        check("ss_clr_idle", {A, B, C, D}, 16'h0000);
        check("ss_clr_idle_running", 16'(running), 16'd0);

        // saturation at 99.99
        press(1'b1, 1'b0);
        wait_for("reach_9999", 16'h9999, 41000);
        step(3);
        check("max_running_before", 16'(running), 16'd1);
        step(1);
        check("max_hold", {A, B, C, D}, 16'h9999);
        check("max_running", 16'(running), 16'd0);
        press(1'b1, 1'b0);
        step(10);
        check("max_ss_ignored", {A, B, C, D}, 16'h9999);
        check("max_ss_running", 16'(running), 16'd0);
        press(1'b0, 1'b1);
        check("max_clr_digits", {A, B, C, D}, 16'h0000);
        step(8);
        check("max_clr_idle", {A, B, C, D}, 16'h0000);
        check("max_clr_running", 16'(running), 16'd0);

`ifdef STOPWATCH_LAP_EN
        // lap snapshot while the live count keeps going
        press(1'b1, 1'b0);
        wait_for("reach_0500", 16'h0500, 2500);
        press_lap();
        check("lap_digits", {A, B, C, D}, 16'h0500);
        check("lap_dots", 16'(dots), 16'b0101);
        step(393);
        check("lap_hold_digits", {A, B, C, D}, 16'h0500);
        check("lap_hold_dots", 16'(dots), 16'b0101);
        check("lap_hold_running", 16'(running), 16'd1);
        step(1);
        press_lap();
        check("lap_release_digits", {A, B, C, D}, 16'h0600);
        check("lap_release_dots", 16'(dots), 16'b0100);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
